// File: rtl/icache_types_pkg.sv
// Shared types for the direct-mapped instruction cache.
// Default geometry: 16 frames of one 32-bit word each.
package icache_types_pkg;

    localparam int ICACHE_NFRAMES = 16;
    localparam int ICACHE_WORD_W  = 32;
    localparam int ICACHE_IDX_W   = $clog2(ICACHE_NFRAMES);
    localparam int ICACHE_TAG_W   = ICACHE_WORD_W - ICACHE_IDX_W - 2;

    // Address overlay for the default geometry: {tag, idx, byte offset}
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    // One cache frame for the default geometry
    typedef struct packed {
        logic                     valid;
        logic [ICACHE_TAG_W-1:0]  tag;
        logic [ICACHE_WORD_W-1:0] data;
    } icframe_t;

    // Controller state: serving hits, or waiting on a memory fill
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icstate_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache between the IF stage
// and the memory arbiter. Hits are answered combinationally in IDLE; a miss
// latches the word-aligned address and holds a read request until memory
// returns data, then installs the frame and returns to IDLE.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
    import icache_types_pkg::*;
#(
    parameter int NFRAMES = ICACHE_NFRAMES,
    parameter int WORD_W  = ICACHE_WORD_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W = $clog2(NFRAMES);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    // Same layouts as the package types, sized by this instance's parameters
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [1:0]       bytoff;
    } addr_fields_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [WORD_W-1:0] data;
    } frame_t;

    icstate_t          state_q, state_d;
    logic [WORD_W-1:0] miss_addr_q, miss_addr_d;
    frame_t            frames_q [NFRAMES];

    addr_fields_t      req_s;
    addr_fields_t      miss_s;
    frame_t            cur_frame_s;
    logic              hit_s;
    logic              fill_en_s;
    logic              unused_bytoff_s;

    assign req_s  = addr_fields_t'(imemaddr);
    assign miss_s = addr_fields_t'(miss_addr_q);
    // Byte offsets never select anything in a one-word frame
    assign unused_bytoff_s = ^{req_s.bytoff, miss_s.bytoff};

    // Hit detection and fetch-port outputs; a hit is only served from IDLE
    always_comb begin
        cur_frame_s = frames_q[req_s.idx];
        hit_s       = 1'b0;
        if (imemREN && (state_q == IDLE) && cur_frame_s.valid &&
            (cur_frame_s.tag == req_s.tag)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        ihit     = hit_s;
        imemload = hit_s ? cur_frame_s.data : '0;
    end

    // Next-state, miss address capture and memory request outputs
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill_en_s   = 1'b0;
        iREN        = 1'b0;
        iaddr       = '0;
        case (state_q)
            IDLE: begin
                if (imemREN && !hit_s) begin
                    miss_addr_d = {imemaddr[WORD_W-1:2], 2'b00};
                    state_d     = FETCH;
                end else begin
                    state_d     = IDLE;
                end
            end
            FETCH: begin
                // Fill always finishes for the latched address
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                if (!iwait) begin
                    fill_en_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d   = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, miss address and frame array; only valid bits are reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            for (int i = 0; i < NFRAMES; i++) begin
                frames_q[i].valid <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (fill_en_s) begin
                frames_q[miss_s.idx] <= {1'b1, miss_s.tag, iload};
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Saturating hit/miss event counters
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_s && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end else begin
            hit_count_d = hit_count_q;
        end
        if ((state_q == IDLE) && (state_d == FETCH) &&
            (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end else begin
            miss_count_d = miss_count_q;
        end
    end

    // Counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
